// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU (A) and load (B) writebacks onto a single register-file write port.
// Define WB_BYPASS_EN to let B write straight through when A is idle and the buffer is empty.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_we,
  input  logic [4:0]               a_wa,
  input  logic [31:0]              a_wdata,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_wa,
  input  logic [31:0]              b_wdata,
  output logic                     rf_we,
  output logic [4:0]               rf_wa,
  output logic [31:0]              rf_wdata,
  input  logic [4:0]               ra1,
  input  logic [4:0]               ra2,
  output logic                     pend1,
  output logic                     pend2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [4:0]       r_wa    [DEPTH];
  logic [31:0]      r_wdata [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [AW-1:0]    r_rdPtr;
  logic [AW-1:0]    r_wrPtr;
  logic [AW:0]      r_count;

  logic w_aWrite;
  logic w_bXfer;
  logic w_bWrite;
  logic w_bypass;
  logic w_push;
  logic w_pop;
  logic w_hit1;
  logic w_hit2;

  assign w_aWrite = reset & a_we & (a_wa != 5'd0);
  assign b_ready  = reset & (r_count < FULL_CNT);
  assign w_bXfer  = b_valid & b_ready;
  assign w_bWrite = w_bXfer & (b_wa != 5'd0);

`ifdef WB_BYPASS_EN
  assign w_bypass = w_bWrite & ~w_aWrite & (r_count == '0);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_bWrite & ~w_bypass;
  assign w_pop  = reset & ~w_aWrite & (r_count != '0);
  assign count  = reset ? r_count : '0;

  always_comb begin
    rf_we    = 1'b0;
    rf_wa    = 5'd0;
    rf_wdata = 32'd0;
    if (w_aWrite) begin
      rf_we    = 1'b1;
      rf_wa    = a_wa;
      rf_wdata = a_wdata;
    end else if (w_pop) begin
      rf_we    = r_live[r_rdPtr];
      rf_wa    = r_wa[r_rdPtr];
      rf_wdata = r_wdata[r_rdPtr];
    end else if (w_bypass) begin
      rf_we    = 1'b1;
      rf_wa    = b_wa;
      rf_wdata = b_wdata;
    end
  end

  // Live bits are cleared on pop, so a set live bit always marks an occupied slot.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i] && (r_wa[i] == ra1)) w_hit1 = 1'b1;
      if (r_live[i] && (r_wa[i] == ra2)) w_hit2 = 1'b1;
    end
  end

  assign pend1 = reset & (ra1 != 5'd0) & w_hit1;
  assign pend2 = reset & (ra2 != 5'd0) & w_hit2;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wa[r_wrPtr]    <= b_wa;
      r_wdata[r_wrPtr] <= b_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      r_live  <= '0;
    end else begin
      // A is younger than anything buffered, so its write kills older buffered writes to the same register.
      if (w_aWrite) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_wa[i] == a_wa) r_live[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_live[r_rdPtr] <= 1'b0;
        r_rdPtr         <= r_rdPtr + 1'b1;
      end
      if (w_push) begin
        r_live[r_wrPtr] <= !(w_aWrite && (b_wa == a_wa));
        r_wrPtr         <= r_wrPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected rf writes go into a scoreboard queue
// and a negedge monitor checks every rf_we against it, including the cycle it lands in.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_we;
  logic [4:0]  a_wa;
  logic [31:0] a_wdata;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_wa;
  logic [31:0] b_wdata;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wdata;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        pend1;
  logic        pend2;
  logic [1:0]  count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic [4:0]  wa;
    logic [31:0] data;
  } wr_t;

  wr_t expQ[$];

  regfile_wb_arbiter #(.DEPTH(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_we     (a_we),
    .a_wa     (a_wa),
    .a_wdata  (a_wdata),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_wa     (b_wa),
    .b_wdata  (b_wdata),
    .rf_we    (rf_we),
    .rf_wa    (rf_wa),
    .rf_wdata (rf_wdata),
    .ra1      (ra1),
    .ra2      (ra2),
    .pend1    (pend1),
    .pend2    (pend2),
    .count    (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expectWrite(input int c, input logic [4:0] wa, input logic [31:0] data);
    wr_t e;
    e.cyc  = c;
    e.wa   = wa;
    e.data = data;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic rst, input logic aWe, input logic [4:0] aWa,
                               input logic [31:0] aData, input logic bValid, input logic [4:0] bWa,
                               input logic [31:0] bData, input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    #1;
    reset   = rst;
    a_we    = aWe;
    a_wa    = aWa;
    a_wdata = aData;
    b_valid = bValid;
    b_wa    = bWa;
    b_wdata = bData;
    ra1     = r1;
    ra2     = r2;
    #2;
  endtask

  task automatic applyIdle(input logic [4:0] r1);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, 5'd0);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rf_we !== 1'b0) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write: got rf_we=%b wa=%0d data=0x%0h at cycle %0d, expected no write",
                 rf_we, rf_wa, rf_wdata, cyc);
      end else begin
        e = expQ.pop_front();
        checkOutput("wr_cycle", cyc, e.cyc);
        checkOutput("wr_addr", {27'd0, rf_wa}, {27'd0, e.wa});
        checkOutput("wr_data", rf_wdata, e.data);
      end
    end
  end

  initial begin
    reset   = 1'b0;
    a_we    = 1'b0;
    a_wa    = 5'd0;
    a_wdata = 32'd0;
    b_valid = 1'b0;
    b_wa    = 5'd0;
    b_wdata = 32'd0;
    ra1     = 5'd0;
    ra2     = 5'd0;

    // Reset held with both requesters active
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b1, 5'd5, 32'h5, 1'b1, 5'd6, 32'h6, 5'd6, 5'd5);
      checkOutput("rst_rf_we", {31'd0, rf_we}, 32'd0);
      checkOutput("rst_b_ready", {31'd0, b_ready}, 32'd0);
      checkOutput("rst_count", {30'd0, count}, 32'd0);
      checkOutput("rst_pend1", {31'd0, pend1}, 32'd0);
      checkOutput("rst_pend2", {31'd0, pend2}, 32'd0);
    end
    applyIdle(5'd0);
    checkOutput("rel_b_ready", {31'd0, b_ready}, 32'd1);
    checkOutput("rel_count", {30'd0, count}, 32'd0);

    // A and B together: A now, B one cycle later
    applyStimulus(1'b1, 1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 5'd6, 5'd0);
    expectWrite(cyc, 5'd5, 32'h11);
    expectWrite(cyc + 1, 5'd6, 32'h22);
    checkOutput("ab_pend1_c0", {31'd0, pend1}, 32'd0);
    checkOutput("ab_b_ready", {31'd0, b_ready}, 32'd1);
    applyIdle(5'd6);
    checkOutput("ab_pend1_c1", {31'd0, pend1}, 32'd1);
    checkOutput("ab_count_c1", {30'd0, count}, 32'd1);
    applyIdle(5'd6);
    checkOutput("ab_pend1_c2", {31'd0, pend1}, 32'd0);
    checkOutput("ab_count_c2", {30'd0, count}, 32'd0);

    // Buffered B to x7 squashed by later A write to x7
    applyStimulus(1'b1, 1'b1, 5'd1, 32'h01, 1'b1, 5'd7, 32'h77, 5'd7, 5'd0);
    expectWrite(cyc, 5'd1, 32'h01);
    checkOutput("sq_pend1_c0", {31'd0, pend1}, 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd7, 32'hAA, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    expectWrite(cyc, 5'd7, 32'hAA);
    checkOutput("sq_pend1_c1", {31'd0, pend1}, 32'd1);
    checkOutput("sq_count_c1", {30'd0, count}, 32'd1);
    applyIdle(5'd7);
    checkOutput("sq_pend1_c2", {31'd0, pend1}, 32'd0);
    checkOutput("sq_count_c2", {30'd0, count}, 32'd1);
    checkOutput("sq_pop_rf_we", {31'd0, rf_we}, 32'd0);
    applyIdle(5'd0);
    checkOutput("sq_count_c3", {30'd0, count}, 32'd0);

    // Same-cycle A and B to the same register: B enqueued dead
    applyStimulus(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h98, 5'd9, 5'd0);
    expectWrite(cyc, 5'd9, 32'h99);
    checkOutput("same_pend1_c0", {31'd0, pend1}, 32'd0);
    applyIdle(5'd9);
    checkOutput("same_count_c1", {30'd0, count}, 32'd1);
    checkOutput("same_pend1_c1", {31'd0, pend1}, 32'd0);
    checkOutput("same_rf_we_c1", {31'd0, rf_we}, 32'd0);
    applyIdle(5'd0);
    checkOutput("same_count_c2", {30'd0, count}, 32'd0);

    // A every cycle starves the drain; B fills the buffer and stalls
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 5'(10 + k), 32'h100 + k, 1'b1, 5'(20 + (k > 2 ? 2 : k)),
                    32'h200 + (k > 2 ? 2 : k), 5'd0, 5'd21);
      expectWrite(cyc, 5'(10 + k), 32'h100 + k);
      checkOutput("full_b_ready", {31'd0, b_ready}, (k < 2) ? 32'd1 : 32'd0);
      checkOutput("full_count", {30'd0, count}, (k < 2) ? k : 2);
      checkOutput("full_pend2", {31'd0, pend2}, (k < 2) ? 32'd0 : 32'd1);
    end
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd22, 32'h202, 5'd0, 5'd0);
    expectWrite(cyc, 5'd20, 32'h200);
    checkOutput("drain_b_ready_c4", {31'd0, b_ready}, 32'd0);
    checkOutput("drain_count_c4", {30'd0, count}, 32'd2);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd22, 32'h202, 5'd0, 5'd0);
    expectWrite(cyc, 5'd21, 32'h201);
    checkOutput("drain_b_ready_c5", {31'd0, b_ready}, 32'd1);
    checkOutput("drain_count_c5", {30'd0, count}, 32'd1);
    applyIdle(5'd0);
    expectWrite(cyc, 5'd22, 32'h202);
    checkOutput("drain_count_c6", {30'd0, count}, 32'd1);
    applyIdle(5'd0);
    checkOutput("drain_count_c7", {30'd0, count}, 32'd0);
    checkOutput("drain_b_ready_c7", {31'd0, b_ready}, 32'd1);

    // Writes to x0 from either side are dropped; A to x0 lets the head drain
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF, 5'd0, 5'd0);
    checkOutput("x0_b_ready", {31'd0, b_ready}, 32'd1);
    checkOutput("x0_b_rf_we", {31'd0, rf_we}, 32'd0);
    applyIdle(5'd0);
    checkOutput("x0_count", {30'd0, count}, 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    checkOutput("x0_a_rf_we", {31'd0, rf_we}, 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44, 5'd4, 5'd0);
    expectWrite(cyc, 5'd2, 32'h22);
    applyStimulus(1'b1, 1'b1, 5'd0, 32'h66, 1'b0, 5'd0, 32'd0, 5'd4, 5'd0);
    expectWrite(cyc, 5'd4, 32'h44);
    checkOutput("x0_pend1", {31'd0, pend1}, 32'd1);
    checkOutput("x0_head_count", {30'd0, count}, 32'd1);
    applyIdle(5'd0);
    checkOutput("x0_drained", {30'd0, count}, 32'd0);

    // Lone B into an idle, empty arbiter
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33, 5'd3, 5'd0);
`ifdef WB_BYPASS_EN
    expectWrite(cyc, 5'd3, 32'h33);
`else
    expectWrite(cyc + 1, 5'd3, 32'h33);
`endif
    checkOutput("lone_pend1_c0", {31'd0, pend1}, 32'd0);
    applyIdle(5'd3);
`ifdef WB_BYPASS_EN
    checkOutput("lone_count_c1", {30'd0, count}, 32'd0);
    checkOutput("lone_pend1_c1", {31'd0, pend1}, 32'd0);
`else
    checkOutput("lone_count_c1", {30'd0, count}, 32'd1);
    checkOutput("lone_pend1_c1", {31'd0, pend1}, 32'd1);
`endif
    applyIdle(5'd0);
    checkOutput("lone_count_c2", {30'd0, count}, 32'd0);

    // Reset while a load is buffered: it must never reach the register file
    applyStimulus(1'b1, 1'b1, 5'd1, 32'h01, 1'b1, 5'd8, 32'h88, 5'd8, 5'd0);
    expectWrite(cyc, 5'd1, 32'h01);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0);
    checkOutput("mid_rst_rf_we", {31'd0, rf_we}, 32'd0);
    checkOutput("mid_rst_count", {30'd0, count}, 32'd0);
    checkOutput("mid_rst_pend1", {31'd0, pend1}, 32'd0);
    checkOutput("mid_rst_b_ready", {31'd0, b_ready}, 32'd0);
    applyIdle(5'd8);
    checkOutput("post_rst_count", {30'd0, count}, 32'd0);
    checkOutput("post_rst_pend1", {31'd0, pend1}, 32'd0);
    checkOutput("post_rst_rf_we", {31'd0, rf_we}, 32'd0);
    checkOutput("post_rst_b_ready", {31'd0, b_ready}, 32'd1);

    applyIdle(5'd0);
    applyIdle(5'd0);
    checkOutput("missing_writes", expQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
